silife_max7219: RTL and testbench
=================================

SILIFE_MAX7219 -- requirements
Module: silife_max7219

Interface
REQ-001 Parameter SEGMENTS, default 4; number of daisy-chained MAX7219 8x8 devices, range 1..8.
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 i_enable  input  1  high = driver active; low = finish current word, then idle.
REQ-005 i_frame_req  input  1  one-cycle pulse requesting a display refresh.
REQ-006 i_brightness  input  4  MAX7219 intensity value, sampled at frame start.
REQ-007 o_row_addr  output  3  grid row 0..7 being fetched.
REQ-008 i_row_data  input  8*SEGMENTS  cells of o_row_addr; bit 8*s+c = device s, column c; valid one cycle after o_row_addr.
REQ-009 o_cs, o_sck, o_mosi  output  1 each  MAX7219 SPI pins, all registered.
REQ-010 o_busy  output  1  high while init or frame in progress.
REQ-011 o_frame_done  output  1  one-cycle pulse after last word of a frame latches.

Function
REQ-012 States: IDLE, LOAD, SHIFT, LATCH; sequencer tracks phase INIT (5 words) or FRAME (9 words).
REQ-013 Word = 16 bits per device: 4 ignored zeros, 4-bit register address, 8-bit data, MSB first; device SEGMENTS-1 shifted first, device 0 last.
REQ-014 LOAD: 2 cycles, o_row_addr held, data captured at end of second cycle; CS stays high.
REQ-015 SHIFT: 32*SEGMENTS cycles; per bit, even cycle sck=0 with mosi updated, odd cycle sck=1; o_cs low for whole SHIFT.
REQ-016 LATCH: 2 cycles, o_cs=1, o_sck=0, o_mosi=0; o_cs rising edge latches all devices.
REQ-017 Word duration = 2+32*SEGMENTS+2 cycles (132 at SEGMENTS=4).
REQ-018 INIT words, same value to all devices, in order: 0x0C=0x01, 0x09=0x00, 0x0B=0x07, 0x0F=0x00, 0x0A=i_brightness.
REQ-019 INIT starts on first cycle i_enable is high after reset or after i_enable was low; frame requests wait until INIT completes.
REQ-020 FRAME words: intensity (0x0A=i_brightness captured at frame start), then digit registers 0x01..0x08 carrying rows 0..7.
REQ-021 i_frame_req while busy sets a single pending flag; further requests coalesce; pending frame starts in cycle after o_frame_done.
REQ-022 From IDLE (init done, enabled), i_frame_req at edge k: LOAD from k+1, o_cs falls at k+3.
REQ-023 i_frame_req with i_enable low is ignored and not remembered.
REQ-024 i_enable dropping mid-frame: current word completes incl. LATCH, then IDLE; no o_frame_done; pending cleared; INIT rerun on re-enable.
REQ-025 o_busy high from first LOAD through final LATCH cycle; low in IDLE.

Reset
REQ-026 rst_n low immediately forces o_cs=1, o_sck=0, o_mosi=0, o_row_addr=0, o_busy=0, o_frame_done=0, pending=0, state IDLE, init-done cleared.
REQ-027 Reset mid-word aborts the word with no further SCK edges; INIT is rerun after release when enabled.

Configuration
REQ-028 Macro SILIFE_MAX7219_COL_REVERSE_EN defined: 8 data bits of each digit word bit-reversed per device (column 0 sent first, as D7); undefined: column 7 sent as D7.
REQ-029 Macro affects digit words only; INIT and intensity words unchanged in both builds.

Verification
REQ-030 Reset release, i_enable=1, SEGMENTS=4 -> 5 INIT words (660 cycles), first decoded word 0x0C01 on all 4 devices, then o_busy=0.
REQ-031 Row r data = 0x01<<r per device, i_brightness=0x5, frame req -> decoder sees 0x0A05, then 0x0101..0x0880; o_frame_done 1188 cycles after LOAD start.
REQ-032 Three i_frame_req pulses during a frame -> exactly one extra frame, starting cycle after o_frame_done.
REQ-033 rst_n asserted at SHIFT bit 20 -> o_cs=1, o_sck=0 same cycle; after release, 0x0C01 sent before any digit word.
REQ-034 Device 3 row 0 = 0x80 with/without SILIFE_MAX7219_COL_REVERSE_EN -> first-shifted digit-1 word data 0x01 / 0x80.
REQ-035 i_enable low during digit word 4 -> word 4 latches, no o_frame_done, o_busy=0 two cycles after CS rise.

Source files
------------

// File: rtl/silife_max7219_if.sv
// Control, row-fetch and SPI pin bundle for the silife_max7219 MAX7219 chain driver.
// master = host/display-memory side, slave = driver side.
interface silife_max7219_if #(
   parameter int SEGMENTS = 4
);
   logic                    i_enable;
   logic                    i_frame_req;
   logic [3:0]              i_brightness;
   logic [2:0]              o_row_addr;
   logic [8*SEGMENTS-1:0]   i_row_data;
   logic                    o_cs;
   logic                    o_sck;
   logic                    o_mosi;
   logic                    o_busy;
   logic                    o_frame_done;

   modport master (
      output i_enable, i_frame_req, i_brightness, i_row_data,
      input  o_row_addr, o_cs, o_sck, o_mosi, o_busy, o_frame_done
   );

   modport slave (
      input  i_enable, i_frame_req, i_brightness, i_row_data,
      output o_row_addr, o_cs, o_sck, o_mosi, o_busy, o_frame_done
   );
endinterface

// File: rtl/silife_max7219.sv
// MAX7219 daisy-chain refresh driver: 5-word INIT sequence, then 9-word frames on request.
// Build option SILIFE_MAX7219_COL_REVERSE_EN: digit words send column 0 as D7.
module silife_max7219 #(
   parameter int SEGMENTS = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   silife_max7219_if.slave bus
);
   localparam int WORD_W    = 16 * SEGMENTS;
   localparam int SHIFT_CYC = 2 * WORD_W;
   localparam int CNT_W     = $clog2(SHIFT_CYC);
   localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(SHIFT_CYC - 1);

   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, LATCH} state_t;
   typedef enum logic {PH_INIT, PH_FRAME} phase_t;

   state_t            state;
   phase_t            phase;
   logic [CNT_W-1:0]  cnt;
   logic [3:0]        word_idx;
   logic [3:0]        bright_q;
   logic              init_done;
   logic              pending;
   logic              stop;
   logic [WORD_W-1:0] sr;
   logic [WORD_W-1:0] word_next;
   logic [3:0]        word_addr;
   logic [7:0]        word_data;
   logic              is_digit;
   logic              last_word;

   function automatic logic [7:0] col_order(input logic [7:0] b);
`ifdef SILIFE_MAX7219_COL_REVERSE_EN
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = b[7-i];
      return r;
`else
      return b;
`endif
   endfunction

   // Register address/data of the current word; digit words take per-device row bytes.
   always_comb begin
      word_addr = 4'h0;
      word_data = 8'h00;
      is_digit  = 1'b0;
      if (phase == PH_INIT) begin
         case (word_idx)
            4'd0:    begin word_addr = 4'hC; word_data = 8'h01; end
            4'd1:    begin word_addr = 4'h9; word_data = 8'h00; end
            4'd2:    begin word_addr = 4'hB; word_data = 8'h07; end
            4'd3:    begin word_addr = 4'hF; word_data = 8'h00; end
            default: begin word_addr = 4'hA; word_data = {4'h0, bright_q}; end
         endcase
      end else if (word_idx == 4'd0) begin
         word_addr = 4'hA;
         word_data = {4'h0, bright_q};
      end else begin
         word_addr = word_idx;
         is_digit  = 1'b1;
      end
      word_next = '0;
      for (int s = 0; s < SEGMENTS; s++) begin
         word_next[16*s +: 16] = {4'h0, word_addr,
                                  is_digit ? col_order(bus.i_row_data[8*s +: 8]) : word_data};
      end
   end

   assign last_word = (phase == PH_INIT) ? (word_idx == 4'd4) : (word_idx == 4'd8);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state            <= IDLE;
         phase            <= PH_INIT;
         cnt              <= '0;
         word_idx         <= '0;
         bright_q         <= '0;
         init_done        <= 1'b0;
         pending          <= 1'b0;
         stop             <= 1'b0;
         sr               <= '0;
         bus.o_cs         <= 1'b1;
         bus.o_sck        <= 1'b0;
         bus.o_mosi       <= 1'b0;
         bus.o_row_addr   <= 3'd0;
         bus.o_busy       <= 1'b0;
         bus.o_frame_done <= 1'b0;
      end else begin
         bus.o_frame_done <= 1'b0;
         if (!bus.i_enable)        pending <= 1'b0;
         else if (bus.i_frame_req) pending <= 1'b1;

         case (state)
            IDLE: begin
               cnt      <= '0;
               word_idx <= '0;
               stop     <= 1'b0;
               if (!bus.i_enable) begin
                  init_done <= 1'b0;
               end else if (!init_done || pending) begin
                  phase      <= init_done ? PH_FRAME : PH_INIT;
                  bright_q   <= bus.i_brightness;
                  state      <= LOAD;
                  bus.o_busy <= 1'b1;
                  // A request landing on the start edge is kept for the next frame.
                  if (init_done) pending <= bus.i_frame_req;
               end
            end

            LOAD: begin
               if (!bus.i_enable) stop <= 1'b1;
               if (cnt == '0) begin
                  cnt <= CNT_W'(1);
               end else begin
                  cnt        <= '0;
                  sr         <= word_next << 1;
                  bus.o_mosi <= word_next[WORD_W-1];
                  bus.o_cs   <= 1'b0;
                  bus.o_sck  <= 1'b0;
                  state      <= SHIFT;
               end
            end

            SHIFT: begin
               if (!bus.i_enable) stop <= 1'b1;
               if (cnt == SHIFT_LAST) begin
                  cnt        <= '0;
                  bus.o_cs   <= 1'b1;
                  bus.o_sck  <= 1'b0;
                  bus.o_mosi <= 1'b0;
                  state      <= LATCH;
               end else begin
                  cnt <= cnt + 1'b1;
                  // Even cycle: SCK low, next bit on MOSI; odd cycle: SCK high.
                  if (!cnt[0]) begin
                     bus.o_sck <= 1'b1;
                  end else begin
                     bus.o_sck  <= 1'b0;
                     bus.o_mosi <= sr[WORD_W-1];
                     sr         <= sr << 1;
                  end
               end
            end

            LATCH: begin
               if (cnt == '0) begin
                  cnt <= CNT_W'(1);
                  if (!bus.i_enable) stop <= 1'b1;
               end else begin
                  cnt <= '0;
                  if (stop || !bus.i_enable) begin
                     state      <= IDLE;
                     bus.o_busy <= 1'b0;
                     init_done  <= 1'b0;
                  end else if (last_word) begin
                     state      <= IDLE;
                     bus.o_busy <= 1'b0;
                     if (phase == PH_INIT) init_done        <= 1'b1;
                     else                  bus.o_frame_done <= 1'b1;
                  end else begin
                     word_idx <= word_idx + 4'd1;
                     state    <= LOAD;
                     // Next word is digit word_idx+1, which carries row word_idx.
                     if (phase == PH_FRAME) bus.o_row_addr <= word_idx[2:0];
                  end
               end
            end

            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_silife_max7219.sv
// Randomized bench for silife_max7219: SPI words decoded from the pins and compared
// with word lists built from the MAX7219 init/frame rules.
module tb_silife_max7219;
   localparam int SEG  = 4;
   localparam int BITS = 16 * SEG;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   silife_max7219_if #(.SEGMENTS(SEG)) bus();
   silife_max7219 #(.SEGMENTS(SEG)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   // Display memory with one-cycle read latency
   logic [7:0]       mem [8][SEG];
   logic [8*SEG-1:0] row_q;
   always @(posedge clk) begin
      for (int s = 0; s < SEG; s++) row_q[8*s +: 8] <= mem[bus.o_row_addr][s];
   end
   assign bus.i_row_data = row_q;

   int cyc = 0;
   int n_done = 0;
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (bus.o_frame_done) n_done <= n_done + 1;
   end

   // SPI decoder: shift on SCK rise while CS low, commit whole chain word on CS rise
   logic [BITS-1:0] dec_q [$];
   logic [BITS-1:0] sh = '0;
   int   nb = 0, n_cs_fall = 0, n_sck = 0, n_abort = 0;
   logic cs_prev = 1'b1, sck_prev = 1'b0;
   always @(bus.o_cs or bus.o_sck) begin
      if (bus.o_cs === 1'b0 && cs_prev === 1'b1) begin
         nb = 0;
         n_cs_fall++;
      end
      if (bus.o_sck === 1'b1 && sck_prev === 1'b0 && bus.o_cs === 1'b0) begin
         sh = {sh[BITS-2:0], bus.o_mosi};
         nb++;
         n_sck++;
      end
      if (bus.o_cs === 1'b1 && cs_prev === 1'b0) begin
         if (nb == BITS) dec_q.push_back(sh);
         else            n_abort++;
         nb = 0;
      end
      cs_prev  = bus.o_cs;
      sck_prev = bus.o_sck;
   end

   int n_chk = 0, n_pass = 0;
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   function automatic logic sig(input int which);
      case (which)
         0:       return bus.o_busy;
         1:       return bus.o_cs;
         default: return bus.o_frame_done;
      endcase
   endfunction

   task automatic wait_lvl(input string tag, input int which, input logic lvl,
                           input int budget, output int t);
      int n = 0;
      while (sig(which) !== lvl && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 64'(sig(which)), 64'(lvl));
      t = cyc;
   endtask

   // Reference word lists: device s occupies bits [16s+15:16s], device SEG-1 shifted first
   logic [BITS-1:0] exp_q [$];

   function automatic logic [7:0] exp_col(input logic [7:0] b);
`ifdef SILIFE_MAX7219_COL_REVERSE_EN
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[7-i] = b[i];
      return r;
`else
      return b;
`endif
   endfunction

   function automatic logic [BITS-1:0] same_all(input logic [3:0] a, input logic [7:0] d);
      logic [BITS-1:0] v;
      for (int s = 0; s < SEG; s++) v[16*s +: 16] = {4'h0, a, d};
      return v;
   endfunction

   function automatic logic [BITS-1:0] digit_word(input int r);
      logic [BITS-1:0] v;
      for (int s = 0; s < SEG; s++) v[16*s +: 16] = {4'h0, 4'(r + 1), exp_col(mem[r][s])};
      return v;
   endfunction

   task automatic expect_init(input logic [3:0] br);
      exp_q.push_back(same_all(4'hC, 8'h01));
      exp_q.push_back(same_all(4'h9, 8'h00));
      exp_q.push_back(same_all(4'hB, 8'h07));
      exp_q.push_back(same_all(4'hF, 8'h00));
      exp_q.push_back(same_all(4'hA, {4'h0, br}));
   endtask

   task automatic expect_frame(input logic [3:0] br, input int nrows);
      exp_q.push_back(same_all(4'hA, {4'h0, br}));
      for (int r = 0; r < nrows; r++) exp_q.push_back(digit_word(r));
   endtask

   task automatic compare_words(input string tag, input int base);
      chk({tag, " nwords"}, 64'(dec_q.size() - base), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++) begin
         if (base + i < dec_q.size())
            chk($sformatf("%s w%0d", tag, i), 64'(dec_q[base+i]), 64'(exp_q[i]));
      end
      exp_q.delete();
   endtask

   task automatic fill_random();
      for (int r = 0; r < 8; r++)
         for (int s = 0; s < SEG; s++) mem[r][s] = 8'($urandom);
   endtask

   task automatic pulse_req();
      bus.i_frame_req = 1'b1;
      @(negedge clk);
      bus.i_frame_req = 1'b0;
   endtask

   task automatic run_frame(input string tag, input logic [3:0] br);
      int k, tb, tc, td, base, nd;
      base = dec_q.size();
      nd   = n_done;
      bus.i_brightness = br;
      k = cyc + 1;
      pulse_req();
      wait_lvl({tag, " busy"}, 0, 1'b1, 10, tb);
      chk({tag, " load start"}, 64'(tb), 64'(k + 1));
      wait_lvl({tag, " cs low"}, 1, 1'b0, 10, tc);
      chk({tag, " cs fall"}, 64'(tc), 64'(k + 3));
      wait_lvl({tag, " done"}, 2, 1'b1, 1300, td);
      chk({tag, " frame cycles"}, 64'(td - tb), 64'd1188);
      chk({tag, " busy at done"}, 64'(bus.o_busy), 64'd0);
      @(negedge clk);
      chk({tag, " done pulse"}, 64'(n_done - nd), 64'd1);
      chk({tag, " done low"}, 64'(bus.o_frame_done), 64'd0);
      expect_frame(br, 8);
      compare_words(tag, base);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0, t1, t2, base, nd, nf, ns, na, n, busy_cyc;
      logic [3:0] br;
      logic [BITS-1:0] w;

      bus.i_enable     = 1'b0;
      bus.i_frame_req  = 1'b0;
      bus.i_brightness = 4'h0;
      for (int r = 0; r < 8; r++)
         for (int s = 0; s < SEG; s++) mem[r][s] = 8'h00;
      repeat (3) @(negedge clk);

      chk("rst cs",   64'(bus.o_cs),         64'd1);
      chk("rst sck",  64'(bus.o_sck),        64'd0);
      chk("rst mosi", 64'(bus.o_mosi),       64'd0);
      chk("rst row",  64'(bus.o_row_addr),   64'd0);
      chk("rst busy", 64'(bus.o_busy),       64'd0);
      chk("rst done", 64'(bus.o_frame_done), 64'd0);

      // Power-up INIT
      br = 4'($urandom_range(0, 15));
      bus.i_brightness = br;
      bus.i_enable     = 1'b1;
      base = dec_q.size();
      rst_n = 1'b1;
      wait_lvl("init busy rise", 0, 1'b1, 10, t0);
      wait_lvl("init busy fall", 0, 1'b0, 2000, t1);
      chk("init cycles", 64'(t1 - t0), 64'd660);
      expect_init(br);
      compare_words("init", base);

      // Walking-one rows, brightness 5
      for (int r = 0; r < 8; r++)
         for (int s = 0; s < SEG; s++) mem[r][s] = 8'h01 << r;
      run_frame("walk", 4'h5);

      // Single lit cell: device 3, row 0, column 7
      for (int r = 0; r < 8; r++)
         for (int s = 0; s < SEG; s++) mem[r][s] = 8'h00;
      mem[0][3] = 8'h80;
      base = dec_q.size();
      run_frame("col7", 4'h3);
      w = dec_q[base+1];
`ifdef SILIFE_MAX7219_COL_REVERSE_EN
      chk("col7 dev3 data", 64'(w[55:48]), 64'h01);
`else
      chk("col7 dev3 data", 64'(w[55:48]), 64'h80);
`endif

      for (int i = 0; i < 3; i++) begin
         fill_random();
         run_frame($sformatf("rnd%0d", i), 4'($urandom_range(0, 15)));
      end

      // Three requests during a frame coalesce into one follow-on frame
      fill_random();
      br = 4'($urandom_range(0, 15));
      bus.i_brightness = br;
      base = dec_q.size();
      nd   = n_done;
      pulse_req();
      wait_lvl("coal busy", 0, 1'b1, 10, t0);
      repeat (3) begin
         repeat ($urandom_range(50, 300)) @(negedge clk);
         pulse_req();
      end
      wait_lvl("coal done1", 2, 1'b1, 1300, t1);
      @(negedge clk);
      chk("coal restart", 64'(bus.o_busy), 64'd1);
      wait_lvl("coal done2", 2, 1'b1, 1300, t2);
      chk("coal second len", 64'(t2 - t1), 64'd1189);
      busy_cyc = 0;
      repeat (300) begin
         @(negedge clk);
         if (bus.o_busy) busy_cyc++;
      end
      chk("coal no third", 64'(busy_cyc), 64'd0);
      chk("coal done count", 64'(n_done - nd), 64'd2);
      expect_frame(br, 8);
      expect_frame(br, 8);
      compare_words("coal", base);

      // Enable dropped during digit word 4
      fill_random();
      br = 4'($urandom_range(0, 15));
      bus.i_brightness = br;
      base = dec_q.size();
      nd   = n_done;
      nf   = n_cs_fall;
      pulse_req();
      n = 0;
      while (n_cs_fall < nf + 5 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      chk("endrop word4", 64'(n_cs_fall - nf), 64'd5);
      repeat (40) @(negedge clk);
      bus.i_enable = 1'b0;
      wait_lvl("endrop cs rise", 1, 1'b1, 300, t0);
      wait_lvl("endrop idle", 0, 1'b0, 10, t1);
      chk("endrop busy delay", 64'(t1 - t0), 64'd2);
      repeat (20) @(negedge clk);
      chk("endrop no done", 64'(n_done - nd), 64'd0);
      expect_frame(br, 4);
      compare_words("endrop", base);

      // Request while disabled is forgotten; re-enable reruns INIT only
      pulse_req();
      busy_cyc = 0;
      repeat (20) begin
         @(negedge clk);
         if (bus.o_busy) busy_cyc++;
      end
      chk("dis req ignored", 64'(busy_cyc), 64'd0);
      br = 4'($urandom_range(0, 15));
      bus.i_brightness = br;
      base = dec_q.size();
      bus.i_enable = 1'b1;
      wait_lvl("reinit busy rise", 0, 1'b1, 10, t0);
      wait_lvl("reinit busy fall", 0, 1'b0, 2000, t1);
      chk("reinit cycles", 64'(t1 - t0), 64'd660);
      busy_cyc = 0;
      repeat (50) begin
         @(negedge clk);
         if (bus.o_busy) busy_cyc++;
      end
      chk("reinit no frame", 64'(busy_cyc), 64'd0);
      expect_init(br);
      compare_words("reinit", base);

      // Asynchronous reset mid-word
      fill_random();
      base = dec_q.size();
      na   = n_abort;
      pulse_req();
      wait_lvl("rstw cs low", 1, 1'b0, 20, t0);
      ns = n_sck;
      n  = 0;
      while (n_sck < ns + 20 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("rstw bit20", 64'(n_sck - ns), 64'd20);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rstw cs",   64'(bus.o_cs),         64'd1);
      chk("rstw sck",  64'(bus.o_sck),        64'd0);
      chk("rstw mosi", 64'(bus.o_mosi),       64'd0);
      chk("rstw busy", 64'(bus.o_busy),       64'd0);
      chk("rstw row",  64'(bus.o_row_addr),   64'd0);
      chk("rstw done", 64'(bus.o_frame_done), 64'd0);
      ns = n_sck;
      repeat (5) @(negedge clk);
      chk("rstw no sck", 64'(n_sck - ns), 64'd0);
      chk("rstw abort", 64'(n_abort - na), 64'd1);
      br = bus.i_brightness;
      rst_n = 1'b1;
      wait_lvl("rstw init rise", 0, 1'b1, 10, t0);
      wait_lvl("rstw init fall", 0, 1'b0, 2000, t1);
      chk("rstw init cycles", 64'(t1 - t0), 64'd660);
      expect_init(br);
      compare_words("rstw", base);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
